// File: rtl/mux2x1_arbiter_if.sv
// mux2x1_arbiter_if: producer/consumer signals of the two-source round-robin output mux
interface mux2x1_arbiter_if #(
  parameter int DATA_WIDTH = 2
);
  logic [DATA_WIDTH-1:0] data_in0;
  logic                  valid_0;
  logic [DATA_WIDTH-1:0] data_in1;
  logic                  valid_1;
  logic                  pause_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  selector;
  logic                  full_0;
  logic                  full_1;
  logic                  overflow_0;
  logic                  overflow_1;
  modport master (
    output data_in0, valid_0, data_in1, valid_1, pause_out,
    input  data_out, valid_out, selector, full_0, full_1, overflow_0, overflow_1
  );
  modport slave (
    input  data_in0, valid_0, data_in1, valid_1, pause_out,
    output data_out, valid_out, selector, full_0, full_1, overflow_0, overflow_1
  );
endinterface

// File: rtl/mux2x1_arbiter.sv
// mux2x1_arbiter: two input FIFOs feeding one registered output through a round-robin grant
module mux2x1_arbiter #(
  parameter int DATA_WIDTH = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           reset_L,
  mux2x1_arbiter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  logic [DATA_WIDTH-1:0] mem [2][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] din [2];
  logic [AW-1:0]         wr_ptr [2];
  logic [AW-1:0]         rd_ptr [2];
  logic [CW-1:0]         count [2];
  logic [1:0]            valid, elig, pop, push_ok, ovf;
  logic                  last_grant, grant_any, grant_idx;
  assign valid = {bus.valid_1, bus.valid_0};
  assign din[0] = bus.data_in0;
  assign din[1] = bus.data_in1;
  assign bus.full_0 = count[0] == FULL;
  assign bus.full_1 = count[1] == FULL;
  assign bus.overflow_0 = ovf[0];
  assign bus.overflow_1 = ovf[1];
  // Grant the lone eligible FIFO, or the one not served last when both compete; a full FIFO still accepts a push when it is popped at the same edge
  always_comb begin
    elig = {count[1] != '0, count[0] != '0} & {2{~bus.pause_out}};
    grant_any = |elig;
    grant_idx = &elig ? ~last_grant : elig[1];
    pop = grant_any ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
    push_ok = valid & ({count[1] != FULL, count[0] != FULL} | pop);
  end
  // FIFO storage needs no reset: only entries covered by the counts are ever read
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++)
      if (push_ok[i]) mem[i][wr_ptr[i]] <= din[i];
  end
  // Pointers, counts, sticky overflow flags, grant history and the registered output stage
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      ovf           <= '0;
      last_grant    <= 1'b1;
      bus.data_out  <= '0;
      bus.valid_out <= 1'b0;
      bus.selector  <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i] <= count[i] + CW'(push_ok[i]) - CW'(pop[i]);
        if (valid[i] && !push_ok[i]) ovf[i] <= 1'b1;
      end
      bus.valid_out <= grant_any;
      if (grant_any) begin
        bus.data_out <= mem[grant_idx][rd_ptr[grant_idx]];
        bus.selector <= grant_idx;
        last_grant   <= grant_idx;
      end
    end
  end
endmodule

// File: tb/tb_mux2x1_arbiter.sv
// tb_mux2x1_arbiter: randomized and scenario stimulus checked against a queue-based model
module tb_mux2x1_arbiter;
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  int q [2][$];
  bit lg = 1'b1;
  int m_data = 0;
  int m_sel = 0;
  int m_valid = 0;
  bit m_ovf [2];
  mux2x1_arbiter_if #(.DATA_WIDTH(2)) bus ();
  mux2x1_arbiter #(.DATA_WIDTH(2), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .reset_L(reset_L),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic compare_all();
    check("data_out", 32'(bus.data_out), m_data);
    check("valid_out", 32'(bus.valid_out), m_valid);
    check("selector", 32'(bus.selector), m_sel);
    check("full_0", 32'(bus.full_0), 32'(q[0].size() == 4));
    check("full_1", 32'(bus.full_1), 32'(q[1].size() == 4));
    check("overflow_0", 32'(bus.overflow_0), 32'(m_ovf[0]));
    check("overflow_1", 32'(bus.overflow_1), 32'(m_ovf[1]));
  endtask
  task automatic model_reset();
    q[0].delete();
    q[1].delete();
    lg = 1'b1;
    m_data = 0;
    m_sel = 0;
    m_valid = 0;
    m_ovf[0] = 1'b0;
    m_ovf[1] = 1'b0;
  endtask
  task automatic cycle(input bit v0, input int d0, input bit v1, input int d1, input bit p);
    bit e0, e1;
    int g;
    bus.valid_0 = v0;
    bus.data_in0 = d0[1:0];
    bus.valid_1 = v1;
    bus.data_in1 = d1[1:0];
    bus.pause_out = p;
    e0 = q[0].size() > 0 && !p;
    e1 = q[1].size() > 0 && !p;
    g = -1;
    if (e0 && e1) g = lg ? 0 : 1;
    else if (e0) g = 0;
    else if (e1) g = 1;
    if (g >= 0) begin
      m_data = q[g].pop_front();
      m_sel = g;
      m_valid = 1;
      lg = g[0];
    end else m_valid = 0;
    if (v0) begin
      if (q[0].size() < 4) q[0].push_back(d0 & 3);
      else m_ovf[0] = 1'b1;
    end
    if (v1) begin
      if (q[1].size() < 4) q[1].push_back(d1 & 3);
      else m_ovf[1] = 1'b1;
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask
  task automatic apply_reset();
    #3;
    bus.valid_0 = 1'b0;
    bus.valid_1 = 1'b0;
    bus.data_in0 = '0;
    bus.data_in1 = '0;
    bus.pause_out = 1'b0;
    reset_L = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    reset_L = 1'b1;
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0);
  endtask
  initial begin
    apply_reset();
    cycle(1, 1, 0, 0, 0);
    cycle(1, 2, 0, 0, 0);
    cycle(1, 3, 0, 0, 0);
    idle(3);
    apply_reset();
    cycle(1, 1, 1, 3, 0);
    cycle(1, 2, 1, 0, 0);
    idle(4);
    apply_reset();
    cycle(1, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 1);
    cycle(1, 2, 0, 0, 1);
    cycle(1, 3, 0, 0, 1);
    cycle(1, 1, 0, 0, 1);
    check("overflow_0 after 5th push", 32'(bus.overflow_0), 32'd1);
    idle(5);
    apply_reset();
    cycle(1, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 1);
    cycle(1, 2, 0, 0, 1);
    cycle(1, 3, 0, 0, 1);
    cycle(1, 2, 0, 0, 0);
    check("overflow_0 push on full pop", 32'(bus.overflow_0), 32'd0);
    idle(6);
    apply_reset();
    for (int k = 0; k < 400; k++)
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), $urandom_range(0, 99) < (((k / 50) % 2) ? 70 : 10));
    cycle(1, 1, 1, 2, 1);
    cycle(1, 3, 1, 0, 1);
    apply_reset();
    check("full_0 cleared by reset", 32'(bus.full_0), 32'd0);
    cycle(1, 2, 1, 1, 0);
    idle(3);
    for (int k = 0; k < 300; k++)
      cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), $urandom_range(0, 99) < 30);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mux2x1_arbiter.md
# mux2x1_arbiter

Two-input round-robin scheduler for the shared 2-bit output mux path. Each source pushes valid-qualified words into its own small FIFO. The arbiter decides every cycle which source owns the shared output register. It drives the mux selector and a registered output stage. The block sits between two independent producers and a single downstream consumer that can pause the stream.

## Interface
- DATA_WIDTH, 2, width of each data word
- FIFO_DEPTH, 4, entries per input FIFO; power of two, at least 2
- clk  input  1  single clock; all state updates on its rising edge
- reset_L  input  1  asynchronous, active-low reset; clears all state immediately
- data_in0  input  DATA_WIDTH  word from source 0
- valid_0  input  1  data_in0 is valid this cycle (push request)
- data_in1  input  DATA_WIDTH  word from source 1
- valid_1  input  1  data_in1 is valid this cycle (push request)
- pause_out  input  1  downstream stall; no pop while high
- data_out  output  DATA_WIDTH  registered output word
- valid_out  output  1  data_out carries a new word this cycle
- selector  output  1  registered source index of the word on data_out; holds while valid_out is 0
- full_0, full_1  output  1  FIFO x holds FIFO_DEPTH entries (decoded from the registered count)
- overflow_0, overflow_1  output  1  sticky: a push to FIFO x was dropped; cleared only by reset

## Operation
- Reset values while reset_L=0: data_out=0, valid_out=0, selector=0, full_x=0, overflow_x=0. FIFO pointers and counts are 0, and last_grant=1.
- Push: at each edge where valid_x=1, data_in_x is written to FIFO x if count_x<FIFO_DEPTH, or if FIFO x is popped at the same edge. Otherwise the word is dropped and overflow_x is set.
- Pop eligibility: FIFO x is eligible when count_x>0 and pause_out=0. Counts are registered, so a word pushed at edge N is eligible from edge N+1.
- Arbitration:
  - If only one FIFO is eligible, grant it.
  - If both are eligible, grant the index != last_grant.
  - If none is eligible, grant nothing.
  - On a grant, last_grant takes the granted index.
- Output stage on a grant at edge E: data_out=head of the granted FIFO, selector=granted index, valid_out=1, and that FIFO is popped.
- Output stage with no grant: valid_out=0; data_out and selector hold their values.
- Counts: count_x updates by +1 on push only, −1 on pop only, and is unchanged on push+pop. Pointers wrap modulo FIFO_DEPTH.
- Reset assertion mid-stream discards all buffered words immediately, with no clock edge required. After release, the first contested grant goes to input 0.

## Timing
- Latency into an empty, unpaused FIFO: a word sampled at edge N appears on data_out with valid_out=1 after edge N+1 (one cycle of buffering).
- Throughput: one word per cycle total. With both sources streaming, the output alternates 0,1,0,1.
- pause_out sampled high at edge E: no pop at E, and valid_out=0 after E. Pushes continue as normal.
- full_x rises the cycle after the push that fills FIFO x.
- At full with a simultaneous pop, a push is accepted and full_x stays 1.
- overflow_x rises the cycle after the dropped push.

## Test plan
- Single stream: valid_0=1 for 3 cycles with data 01,10,11.
  - valid_out goes high one cycle after the first push.
  - data_out is 01,10,11 on consecutive cycles, selector=0 throughout.
  - Then valid_out=0 and data_out holds 11.
- Contention: both sources push together; source 0 sends 01 then 10, source 1 sends 11 then 00.
  - data_out order is 01,11,10,00 with selector 0,1,0,1.
- Pause and overflow: pause_out=1 while pushing 5 words (00,01,10,11,01) on source 0.
  - full_0=1 after the 4th push; the 5th is dropped and overflow_0=1.
  - Release pause: 00,01,10,11 emerge on 4 consecutive cycles.
  - full_0 then drops; overflow_0 stays 1.
- Full plus simultaneous pop: fill FIFO 0 while paused, then release pause and push 10 in the same cycle.
  - The word is accepted, overflow_0 stays 0, and 10 emerges as the 5th word.
- Asynchronous reset mid-stream: assert reset_L=0 between clock edges while both FIFOs are non-empty.
  - All outputs become 0 immediately.
  - After release, new words pushed on both sources in the same cycle emerge source 0 first.
